// File: rtl/bus_alu_datapath.sv
// bus_alu_datapath: 16-bit datapath slice with a priority-resolved 13-source
// bus multiplexer, an add/sub unit (A op bus -> G) and an OR unit (B | bus -> H).
// Every select and load enable comes from the external control FSM.
// Resetn is active-high, despite its name, and clears A, B, G and H asynchronously.
module bus_alu_datapath #(
  parameter int N = 16
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic [N-1:0]   DIN,
  input  logic [8*N-1:0] Rflat,
  input  logic [N-1:0]   Iin_data,
  input  logic [N-1:0]   Jin_data,
  input  logic [12:0]    Control,
  input  logic           AddSubControl,
  input  logic           Ain,
  input  logic           Gin,
  input  logic           Bin,
  input  logic           Hin,
  output logic [N-1:0]   BusWires,
  output logic [N-1:0]   A,
  output logic [N-1:0]   G,
  output logic [N-1:0]   B,
  output logic [N-1:0]   H
);

  localparam int NSRC = 13;

  logic [N-1:0] r_a;
  logic [N-1:0] r_b;
  logic [N-1:0] r_g;
  logic [N-1:0] r_h;

  logic [N-1:0] w_src [NSRC];
  logic [N-1:0] w_bus;
  logic [N-1:0] w_sum;
  logic [N-1:0] w_orv;

  // Bus source table, indexed by Control bit position. G and H feed back
  // from their registers, so the bus always shows the pre-edge value.
  genvar gk;
  generate
    for (gk = 0; gk < 8; gk++) begin : g_rsrc
      assign w_src[gk] = Rflat[gk*N +: N];
    end
  endgenerate
  assign w_src[8]  = r_g;
  assign w_src[9]  = r_h;
  assign w_src[10] = Iin_data;
  assign w_src[11] = Jin_data;
  assign w_src[12] = DIN;

  // Priority bus mux: the loop runs from high index to low, so the lowest
  // set Control bit is written last and wins. No bit set gives zero.
  always_comb begin
    w_bus = '0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (Control[k]) begin
        w_bus = w_src[k];
      end
    end
  end

  // Add/sub unit: the result wraps modulo 2^N and the carry/borrow is dropped.
  always_comb begin
    w_sum = '0;
    if (AddSubControl) begin
      w_sum = r_a - w_bus;
    end else begin
      w_sum = r_a + w_bus;
    end
  end

  // OR unit: bitwise OR of B and the bus.
  always_comb begin
    w_orv = r_b | w_bus;
  end

  // A/G registers. G samples the sum formed from the old A, so loading A and
  // G on the same edge is well defined.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_a <= '0;
      r_g <= '0;
    end else begin
      if (Ain) r_a <= w_bus;
      if (Gin) r_g <= w_sum;
    end
  end

  // B/H registers. These behave the same way as A/G, with the OR unit
  // supplying H.
  always_ff @(posedge Clock or posedge Resetn) begin
    if (Resetn) begin
      r_b <= '0;
      r_h <= '0;
    end else begin
      if (Bin) r_b <= w_bus;
      if (Hin) r_h <= w_orv;
    end
  end

  assign BusWires = w_bus;
  assign A        = r_a;
  assign B        = r_b;
  assign G        = r_g;
  assign H        = r_h;

endmodule

// File: tb/tb_bus_alu_datapath.sv
// Scoreboard bench for bus_alu_datapath. The stimulus process applies inputs
// just after each rising edge and queues the values it expects. The monitor
// takes every queued item on the following falling edge and compares it.
module tb_bus_alu_datapath;

  localparam int N = 16;
  localparam int S_BUS = 0, S_A = 1, S_B = 2, S_G = 3, S_H = 4;

  logic           Clock = 1'b0;
  logic           Resetn;
  logic [N-1:0]   DIN;
  logic [8*N-1:0] Rflat;
  logic [N-1:0]   Iin_data, Jin_data;
  logic [12:0]    Control;
  logic           AddSubControl, Ain, Gin, Bin, Hin;
  logic [N-1:0]   BusWires, A, G, B, H;

  bus_alu_datapath #(.N(N)) dut (
    .Clock(Clock), .Resetn(Resetn), .DIN(DIN), .Rflat(Rflat),
    .Iin_data(Iin_data), .Jin_data(Jin_data), .Control(Control),
    .AddSubControl(AddSubControl), .Ain(Ain), .Gin(Gin), .Bin(Bin), .Hin(Hin),
    .BusWires(BusWires), .A(A), .G(G), .B(B), .H(H)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    int          sel;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic expect_val(input int sel, input logic [15:0] val, input string name);
    exp_t e;
    e.sel  = sel;
    e.exp  = val;
    e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic [12:0] ctrl, input logic sub,
                       input logic ain, input logic gin, input logic bin, input logic hin);
    @(posedge Clock);
    #1;
    Control       = ctrl;
    AddSubControl = sub;
    Ain = ain; Gin = gin; Bin = bin; Hin = hin;
  endtask

  // Monitor: on each falling edge, compare every queued expectation with the DUT.
  initial begin
    exp_t        e;
    logic [15:0] act;
    forever begin
      @(negedge Clock);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        case (e.sel)
          S_BUS:   act = BusWires;
          S_A:     act = A;
          S_B:     act = B;
          S_G:     act = G;
          default: act = H;
        endcase
        checks++;
        if (act !== e.exp) begin
          failures++;
          $display("FAIL %s: got 0x%04h expected 0x%04h", e.name, act, e.exp);
        end
      end
    end
  end

  logic [15:0] sweep_exp [13];

  initial begin
    // Register file contents: R0..R7
    Rflat    = {16'h7777, 16'h0001, 16'hFFFF, 16'h0003, 16'h0005, 16'h00F0, 16'h0F0F, 16'hA0A0};
    Iin_data = 16'h1234;
    Jin_data = 16'h5678;
    DIN      = 16'hBEEF;
    Resetn   = 1'b1;
    Control  = 13'h0008;
    AddSubControl = 1'b0;
    Ain = 1'b1; Gin = 1'b1; Bin = 1'b1; Hin = 1'b1;

    // Reset must dominate the enables across a clock edge.
    drive(13'h0008, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    expect_val(S_A, 16'h0000, "rst_dom_A");
    expect_val(S_G, 16'h0000, "rst_dom_G");
    expect_val(S_B, 16'h0000, "rst_dom_B");
    expect_val(S_H, 16'h0000, "rst_dom_H");
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_BUS, 16'h0000, "bus_ctrl0");
    Resetn = 1'b0;

    // Add: A = R3 (5), then G = 5 + R4 (3) = 8
    drive(13'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_val(S_BUS, 16'h0005, "bus_r3");
    drive(13'h0010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val(S_A, 16'h0005, "add_A");
    expect_val(S_BUS, 16'h0003, "bus_r4");
    drive(13'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_G, 16'h0008, "add_G");
    expect_val(S_BUS, 16'h0008, "bus_G");

    // Sub: 5 - 3 = 2
    drive(13'h0008, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(13'h0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(13'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_G, 16'h0002, "sub_G");
    // Sub wrap: 3 - 5 = 0xFFFE
    drive(13'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(13'h0008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val(S_A, 16'h0003, "subw_A");
    drive(13'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_G, 16'hFFFE, "subw_G");

    // Add carry drop: 0xFFFF + 1 = 0
    drive(13'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(13'h0040, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val(S_A, 16'hFFFF, "carry_A");
    drive(13'h0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_G, 16'h0000, "carry_G");

    // Ain and Gin on the same edge: G = old A (0xFFFF) + 5 = 0x0004, and A = 5
    drive(13'h0008, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_A, 16'h0005, "simul_A");
    expect_val(S_G, 16'h0004, "simul_G");

    // G fed back onto the bus while G loads: bus shows 4, and G becomes 5 + 4 = 9
    drive(13'h0100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_val(S_BUS, 16'h0004, "fb_bus");
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_G, 16'h0009, "fb_G");

    // OR: B = R2 (0x00F0), H = 0x00F0 | R1 (0x0F0F) = 0x0FFF
    drive(13'h0004, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(13'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_val(S_B, 16'h00F0, "or_B");
    expect_val(S_BUS, 16'h0F0F, "bus_r1");
    drive(13'h0200, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_H, 16'h0FFF, "or_H");
    expect_val(S_BUS, 16'h0FFF, "bus_H");

    // Bin and Hin on the same edge: H = old B (0x00F0) | R7 (0x7777) = 0x77F7, and B = 0x7777
    drive(13'h0080, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_B, 16'h7777, "simul_B");
    expect_val(S_H, 16'h77F7, "simul_H");

    // One-hot mux sweep (G = 0x0009, H = 0x77F7 at this point)
    sweep_exp = '{16'hA0A0, 16'h0F0F, 16'h00F0, 16'h0005, 16'h0003, 16'hFFFF, 16'h0001,
                  16'h7777, 16'h0009, 16'h77F7, 16'h1234, 16'h5678, 16'hBEEF};
    for (int k = 0; k < 13; k++) begin
      drive(13'(1 << k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_val(S_BUS, sweep_exp[k], $sformatf("sweep_bit%0d", k));
    end
    drive(13'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_BUS, 16'hA0A0, "prio_0005");
    drive(13'h1800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_BUS, 16'h5678, "prio_J_DIN");
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_BUS, 16'h0000, "bus_zero");

    // Reset pulse between edges must clear A, B, G and H without a clock edge.
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    expect_val(S_A, 16'h0000, "async_A");
    expect_val(S_B, 16'h0000, "async_B");
    expect_val(S_G, 16'h0000, "async_G");
    expect_val(S_H, 16'h0000, "async_H");
    expect_val(S_BUS, 16'h0000, "async_bus");
    @(negedge Clock);
    #1;
    Resetn = 1'b0;

    // Operation after reset is released: A = DIN
    drive(13'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(13'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_val(S_A, 16'hBEEF, "post_rst_A");

    // Wait, with a bound, for the monitor to take every queued item.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge Clock);
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
